// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: state encoding, requester IDs, latency bound.
// Pure definitions; no latency or flow control of its own.
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between two requesters: round-robin or fixed m0 priority.
// Zero latency; no backpressure, the caller decides when the pick is consumed.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic vld,
    output logic id
);

    always_comb begin
        vld = req0 | req1;
        id  = REQ_CORE;
        if (req0 && req1) begin
            id = (FAIR != 0) ? ~last_grant : REQ_CORE;
        end else if (req1) begin
            id = REQ_LOAD;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (m0) and the loader/debug port (m1).
// Ack 2 cycles after grant for stores, 1+MEM_LAT for loads; requesters stall holding req until ack.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int FAIR    = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_size,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_size,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic pick_req0, pick_req1, pick_vld, pick_id;
    logic in_resp;

    assign in_resp = (state_q == ST_RESP);

    // The requester being acked this cycle is masked so only the other side can chain.
    assign pick_req0 = m0_req && !(in_resp && grant_q == REQ_CORE);
    assign pick_req1 = m1_req && !(in_resp && grant_q == REQ_LOAD);

    dmem_arb_pick #(
        .FAIR (FAIR)
    ) u_pick (
        .req0       (pick_req0),
        .req1       (pick_req1),
        .last_grant (last_grant_q),
        .vld        (pick_vld),
        .id         (pick_id)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (pick_vld) begin
                    state_d      = ST_ACCESS;
                    grant_d      = pick_id;
                    last_grant_d = pick_id;
                    we_d         = pick_id ? m1_we    : m0_we;
                    addr_d       = pick_id ? m1_addr  : m0_addr;
                    wdata_d      = pick_id ? m1_wdata : m0_wdata;
                    size_d       = pick_id ? m1_size  : m0_size;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!we_q && MEM_LAT > 1) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_CORE;
            last_grant_q <= REQ_LOAD;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            cnt_q        <= cnt_d;
        end
    end

    logic [DATA_W-1:0] resp_rdata;

    // Load data is forwarded straight from memory in the RESP cycle; stores return zero.
    assign resp_rdata = (in_resp && !we_q) ? mem_rdata : '0;

    assign m0_ack    = in_resp && (grant_q == REQ_CORE);
    assign m1_ack    = in_resp && (grant_q == REQ_LOAD);
    assign m0_rdata  = m0_ack ? resp_rdata : '0;
    assign m1_rdata  = m1_ack ? resp_rdata : '0;

    assign mem_read  = (state_q == ST_ACCESS) && !we_q;
    assign mem_write = (state_q == ST_ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_sel   = size_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed latency/fairness/reset cases plus randomized two-port traffic
// scored against a word-array reference memory updated in ack order.
module tb_dmem_arbiter;

    localparam int          LAT_A = 3;
    localparam int          NRAND = 1000;
    localparam logic [31:0] B_RD  = 32'hA5A5_0001;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    // Instance A: MEM_LAT = 3, round-robin
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [2:0]  m0_size = 0, m1_size = 0;
    logic        m0_ack, m1_ack, mem_read, mem_write, busy, grant_id;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_sel;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A), .FAIR(1)) u_dut_a (
        .clk_in(clk_in), .reset(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    // Instance B: MEM_LAT = 1, fixed priority
    logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
    logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0;
    logic [2:0]  b_m0_size = 0, b_m1_size = 0;
    logic        b_m0_ack, b_m1_ack, b_mem_read, b_mem_write, b_busy, b_grant_id;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic [2:0]  b_mem_sel;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .FAIR(0)) u_dut_b (
        .clk_in(clk_in), .reset(rst_n),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_size(b_m0_size), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_size(b_m1_size), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_wdata(b_mem_wdata), .mem_sel(b_mem_sel), .mem_rdata(B_RD),
        .busy(b_busy), .grant_id(b_grant_id)
    );

    // Data memory behind instance A: read data appears LAT_A cycles after the strobe cycle
    logic [31:0] mem_arr [64] = '{default: 32'h0};
    logic [31:0] rd_pipe [LAT_A];
    always @(posedge clk_in) begin
        if (mem_write) mem_arr[mem_addr[7:2]] <= mem_wdata;
        rd_pipe[0] <= mem_read ? mem_arr[mem_addr[7:2]] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT_A; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT_A-1];

    logic [31:0] ref_mem [64];
    int n_checks = 0, n_errors = 0;
    int n_ack0 = 0, n_ack1 = 0;

    always @(negedge clk_in) begin
        if (m0_ack) n_ack0++;
        if (m1_ack) n_ack1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit p, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
        if (p) begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_size = s;
        end else begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_size = s;
        end
    endtask

    task automatic set_req(input bit p, input logic v);
        if (p) m1_req = v;
        else   m0_req = v;
    endtask

    // Issue one request on port p (called at a negedge) and follow it to its ack.
    task automatic do_req(input bit p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] s, input bit drop_early, output int lat);
        int nstb;
        bit got;
        nstb = 0;
        got  = 0;
        lat  = 0;
        drive(p, 1'b1, w, a, d, s);
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk_in);
            if (drop_early && c == 1) set_req(p, 1'b0);
            if ((mem_read || mem_write) && grant_id == p) begin
                nstb++;
                chk("stb_we", 32'(mem_write), 32'(w));
                chk("stb_addr", mem_addr, a);
                chk("stb_sel", 32'(mem_sel), 32'(s));
                if (w) chk("stb_wdata", mem_wdata, d);
            end
            if (p ? m1_ack : m0_ack) begin
                got = 1;
                lat = c;
                chk("ack_gid", 32'(grant_id), 32'(p));
                chk("ack_other", 32'(p ? m0_ack : m1_ack), 32'd0);
                if (w) begin
                    chk("st_rdata", p ? m1_rdata : m0_rdata, 32'd0);
                    ref_mem[a[7:2]] = d;
                end else begin
                    chk("ld_rdata", p ? m1_rdata : m0_rdata, ref_mem[a[7:2]]);
                end
                set_req(p, 1'b0);
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("one_strobe", 32'(nstb), 32'd1);
    endtask

    task automatic rand_req(input bit p);
        int          lat;
        logic [31:0] a;
        repeat ($urandom_range(0, 2)) @(negedge clk_in);
        a = 32'($urandom_range(0, 63)) << 2;
        do_req(p, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), 1'b0, lat);
    endtask

    initial begin
        int l0, l1, cnt, s0, s1;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // Fixed priority, MEM_LAT = 1 (instance B)
        @(negedge clk_in);
        b_m0_req = 1; b_m0_we = 1; b_m0_addr = 32'h20; b_m0_wdata = 32'h1111;
        @(negedge clk_in);
        chk("b_st_write", 32'(b_mem_write), 32'd1);
        @(negedge clk_in);
        chk("b_st_ack", 32'(b_m0_ack), 32'd1);
        b_m0_req = 0;
        @(negedge clk_in);
        b_m0_req = 1; b_m1_req = 1; b_m1_we = 0; b_m1_addr = 32'h24;
        @(negedge clk_in);
        chk("b_fixed_gid", 32'(b_grant_id), 32'd0);
        @(negedge clk_in);
        chk("b_m0_ack", 32'(b_m0_ack), 32'd1);
        b_m0_req = 0;
        @(negedge clk_in);
        chk("b_b2b_gid", 32'(b_grant_id), 32'd1);
        chk("b_b2b_read", 32'(b_mem_read), 32'd1);
        @(negedge clk_in);
        chk("b_m1_ack", 32'(b_m1_ack), 32'd1);
        chk("b_m1_rdata", b_m1_rdata, B_RD);
        b_m1_req = 0;
        @(negedge clk_in);
        chk("b_idle", 32'(b_busy), 32'd0);

        // Reset during ACCESS of an m1 store
        drive(1'b1, 1'b1, 1'b1, 32'h8, 32'h55AA_55AA, 3'b010);
        @(negedge clk_in);
        chk("pre_rst_write", 32'(mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_write", 32'(mem_write), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        m1_req = 0;
        @(negedge clk_in);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (m1_ack) cnt++;
        end
        chk("arst_no_ack", 32'(cnt), 32'd0);

        // Single store and single load with MEM_LAT = 3
        do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b0, l0);
        chk("st_lat", 32'(l0), 32'd2);
        @(negedge clk_in);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, l1);
        chk("ld_lat", 32'(l1), 32'd4);
        chk("ld_val", ref_mem[4], 32'hDEAD_BEEF);
        @(negedge clk_in);

        // Round-robin from IDLE: m0 was granted last, so m1 wins the tie
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 3'b000, 1'b0, l0);
        @(negedge clk_in);
        fork
            do_req(1'b0, 1'b1, 32'h30, 32'h0000_3030, 3'b001, 1'b0, l0);
            do_req(1'b1, 1'b1, 32'h34, 32'h0000_3434, 3'b000, 1'b0, l1);
        join
        chk("rr_m1_lat", 32'(l1), 32'd2);
        chk("rr_m0_lat", 32'(l0), 32'd4);

        // Both request at the first edge after reset: m0 first, then m1 back-to-back
        @(negedge clk_in);
        rst_n = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
        fork
            do_req(1'b0, 1'b1, 32'h20, 32'h1234_5678, 3'b010, 1'b0, l0);
            do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b100, 1'b0, l1);
        join
        chk("b2b_m0_lat", 32'(l0), 32'd2);
        chk("b2b_m1_lat", 32'(l1), 32'd6);

        // m0 drops req right after grant; the load still completes once
        @(negedge clk_in);
        #1 s0 = n_ack0;
        do_req(1'b0, 1'b0, 32'h4, 32'h0, 3'b010, 1'b1, l0);
        chk("drop_lat", 32'(l0), 32'd4);
        @(negedge clk_in);
        chk("drop_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_in);
        #1 chk("drop_one_ack", 32'(n_ack0 - s0), 32'd1);

        // Randomized traffic on both ports
        @(negedge clk_in);
        s0 = n_ack0;
        s1 = n_ack1;
        fork
            for (int i = 0; i < NRAND; i++) rand_req(1'b0);
            for (int j = 0; j < NRAND; j++) rand_req(1'b1);
        join
        repeat (4) @(negedge clk_in);
        #1;
        chk("rand_acks0", 32'(n_ack0 - s0), 32'(NRAND));
        chk("rand_acks1", 32'(n_ack1 - s1), 32'(NRAND));
        chk("rand_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
